// File: rtl/ps2_pkg.sv
// Shared scan-code constants, frame FSM state type and the key-event record
// used by the PS/2 receive controller.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DN_NP = 8'h73;
    localparam logic [7:0] KEY_DN_AR = 8'h72;
    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_S     = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    // Keyboard status/ack bytes that carry no key information.
    function automatic logic is_discard(input logic [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    endfunction

    // Which paddle bit(s) an event refers to.
    function automatic logic [3:0] key_mask(input ps2_evt_t e);
        logic [3:0] m;
        m    = '0;
        m[0] = (e.code == KEY_UP);
        m[1] = (e.code == KEY_DN_NP && !e.ext) || (e.code == KEY_DN_AR && e.ext);
        m[2] = (e.code == KEY_W) && !e.ext;
        m[3] = (e.code == KEY_S) && !e.ext;
        return m;
    endfunction

endpackage

// File: rtl/ps2_rx_ctrl_line_filter.sv
// Two-flop synchronizer followed by a stability filter: the output only follows
// the pin after FILTER_CYC consecutive identical synchronized samples.
module ps2_line_filter #(
    parameter int FILTER_CYC = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);

    localparam int CW = $clog2(FILTER_CYC + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // NOTE: the bus idles high, so the whole chain resets to 1 to avoid a false falling edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            filt  <= 1'b1;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_CYC - 1)) begin
                filt <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 host receiver: frame sequencing with watchdog, make/break/extended
// prefix decoding, paddle key levels and a small registered-head event FIFO.
module ps2_rx_ctrl
    import ps2_pkg::*;
#(
    parameter int FILTER_CYC  = 8,
    parameter int TIMEOUT_CYC = 200000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic [3:0] key_state,
    output logic       err_parity,
    output logic       err_frame,
    output logic       overflow
);

    localparam int WDW = $clog2(TIMEOUT_CYC);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

    // ---------------- input conditioning ----------------
    logic clk_f, data_f, clk_prev, fall_edge;

    ps2_line_filter #(.FILTER_CYC(FILTER_CYC)) u_clk_filt (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (ps2_clk),
        .filt (clk_f)
    );

    ps2_line_filter #(.FILTER_CYC(FILTER_CYC)) u_data_filt (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (ps2_data),
        .filt (data_f)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) clk_prev <= 1'b1;
        else        clk_prev <= clk_f;
    end

    assign fall_edge = clk_prev & ~clk_f;

    // ---------------- frame FSM ----------------
    frame_state_t   state, state_n;
    logic [2:0]     bit_cnt, bit_cnt_n;
    logic [7:0]     shift_q, shift_n;
    logic           parity_q, parity_n;
    logic           byte_done, byte_done_n;
    logic           err_frame_n, err_parity_n;
    logic [WDW-1:0] wd_cnt;
    logic           timeout;

    assign timeout = (state != ST_IDLE) && (wd_cnt == WDW'(TIMEOUT_CYC - 1));

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift_q;
        parity_n     = parity_q;
        byte_done_n  = 1'b0;
        err_frame_n  = 1'b0;
        err_parity_n = 1'b0;
        if (timeout) begin
            state_n     = ST_IDLE;
            err_frame_n = 1'b1;
        end else if (fall_edge) begin
            unique case (state)
                ST_IDLE: begin
                    if (!data_f) begin
                        state_n   = ST_DATA;
                        bit_cnt_n = '0;
                    end else begin
                        err_frame_n = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_n   = {data_f, shift_q[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = ST_PARITY;
                end
                ST_PARITY: begin
                    parity_n = data_f;
                    state_n  = ST_STOP;
                end
                ST_STOP: begin
                    state_n = ST_IDLE;
                    if (!data_f)                     err_frame_n  = 1'b1;
                    else if (!(^{shift_q, parity_q})) err_parity_n = 1'b1;
                    else                             byte_done_n  = 1'b1;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            byte_done  <= 1'b0;
            err_frame  <= 1'b0;
            err_parity <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift_q    <= shift_n;
            parity_q   <= parity_n;
            byte_done  <= byte_done_n;
            err_frame  <= err_frame_n;
            err_parity <= err_parity_n;
        end
    end

    // Watchdog measures the gap between clock edges inside a frame only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                         wd_cnt <= '0;
        else if (state == ST_IDLE || fall_edge || timeout) wd_cnt <= '0;
        else                                                wd_cnt <= wd_cnt + WDW'(1);
    end

    // ---------------- prefix decoder ----------------
    logic     ext_q, brk_q, commit_vld;
    ps2_evt_t commit_evt;
    logic [3:0] commit_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            commit_vld <= 1'b0;
            commit_evt <= '0;
        end else begin
            commit_vld <= 1'b0;
            if (byte_done) begin
                if (shift_q == PS2_EXT) begin
                    ext_q <= 1'b1;
                end else if (shift_q == PS2_BRK) begin
                    brk_q <= 1'b1;
                end else begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                    if (!is_discard(shift_q)) begin
                        commit_vld <= 1'b1;
                        commit_evt <= '{ext: ext_q, brk: brk_q, code: shift_q};
                    end
                end
            end
        end
    end

    assign commit_mask = key_mask(commit_evt);

    // Key levels follow every committed event, whether or not the FIFO takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           key_state <= '0;
        else if (commit_vld) key_state <= commit_evt.brk ? (key_state & ~commit_mask)
                                                         : (key_state | commit_mask);
    end

    // ---------------- event FIFO ----------------
    ps2_evt_t        mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr, rd_ptr_n;
    logic [CW-1:0]   count, count_n, remain;
    logic            pop, push, full;
    ps2_evt_t        head, head_n;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign pop      = evt_valid & evt_ready;
    assign push     = commit_vld & (~full | pop);
    assign rd_ptr_n = rd_ptr + AW'(pop);
    assign remain   = count - CW'(pop);
    assign count_n  = remain + CW'(push);

    // The head register shows the oldest entry left after this cycle's pop.
    always_comb begin
        head_n = head;
        if (remain != '0) head_n = mem[rd_ptr_n];
        else if (push)    head_n = commit_evt;
    end

    // NOTE: storage carries no reset; only pointers, count and the head register define visible state.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= commit_evt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            evt_valid <= 1'b0;
            head      <= '0;
            overflow  <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(push);
            rd_ptr    <= rd_ptr_n;
            count     <= count_n;
            evt_valid <= (count_n != '0);
            head      <= head_n;
            overflow  <= commit_vld & full & ~pop;
        end
    end

    assign evt_code  = head.code;
    assign evt_ext   = head.ext;
    assign evt_break = head.brk;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Directed bench for ps2_rx_ctrl: bit-banged PS/2 frames with hand-computed
// expected key levels, events and error pulses.
module tb_ps2_rx_ctrl;

    localparam int FILT  = 8;
    localparam int TMO   = 400;
    localparam int DEPTH = 4;
    localparam int HALF  = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_ext, evt_break;
    logic [3:0] key_state;
    logic       err_parity, err_frame, overflow;

    int n_pass = 0;
    int n_total = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;
    int ovf_cnt = 0;

    ps2_rx_ctrl #(.FILTER_CYC(FILT), .TIMEOUT_CYC(TMO), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_ext   (evt_ext),
        .evt_break (evt_break),
        .key_state (key_state),
        .err_parity(err_parity),
        .err_frame (err_frame),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_parity) perr_cnt++;
        if (err_frame)  ferr_cnt++;
        if (overflow)   ovf_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL bench_time_limit: run did not complete, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "bench time limit reached");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        cyc(HALF);
        ps2_clk = 1'b0;
        cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~(^b) ^ par_flip);
        send_bit(stop);
        ps2_data = 1'b1;
        cyc(2 * HALF);
    endtask

    task automatic pop_evt(output logic v, output logic [9:0] e);
        v = evt_valid;
        e = {evt_ext, evt_break, evt_code};
        if (v) begin
            evt_ready = 1'b1;
            cyc(1);
            evt_ready = 1'b0;
            cyc(1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(3);
        n_total++;
        if ({evt_valid, evt_code, evt_ext, evt_break, key_state, err_parity, err_frame, overflow} !== 17'h0)
            $display("FAIL reset_outputs: got %h required 0",
                     {evt_valid, evt_code, evt_ext, evt_break, key_state, err_parity, err_frame, overflow});
        else n_pass++;
        rst_n = 1'b1;
        cyc(5);
        n_total++;
        if ({evt_valid, key_state, err_frame} !== 6'h0)
            $display("FAIL reset_release: got %h required 0", {evt_valid, key_state, err_frame});
        else n_pass++;
    endtask

    task automatic test_clean_frame();
        int pb, fb;
        logic v;
        logic [9:0] e;
        pb = perr_cnt;
        fb = ferr_cnt;
        send_frame(8'h1D, 1'b0, 1'b1);
        n_total++;
        if (key_state !== 4'b0100) $display("FAIL clean_keys: got %b required 0100", key_state);
        else n_pass++;
        n_total++;
        if ((perr_cnt - pb) != 0 || (ferr_cnt - fb) != 0)
            $display("FAIL clean_no_err: got par=%0d frm=%0d required 0 0", perr_cnt - pb, ferr_cnt - fb);
        else n_pass++;
        pop_evt(v, e);
        n_total++;
        if (v !== 1'b1 || e !== 10'h01D) $display("FAIL clean_event: got v=%b %h required v=1 01d", v, e);
        else n_pass++;
        n_total++;
        if (evt_valid !== 1'b0) $display("FAIL clean_empty: got %b required 0", evt_valid);
        else n_pass++;
    endtask

    task automatic test_extended();
        logic v;
        logic [9:0] e;
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        n_total++;
        if (key_state !== 4'b0101) $display("FAIL ext_make_keys: got %b required 0101", key_state);
        else n_pass++;
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        n_total++;
        if (key_state !== 4'b0100) $display("FAIL ext_break_keys: got %b required 0100", key_state);
        else n_pass++;
        pop_evt(v, e);
        n_total++;
        if (v !== 1'b1 || e !== 10'h275) $display("FAIL ext_make_event: got v=%b %h required v=1 275", v, e);
        else n_pass++;
        pop_evt(v, e);
        n_total++;
        if (v !== 1'b1 || e !== 10'h375) $display("FAIL ext_break_event: got v=%b %h required v=1 375", v, e);
        else n_pass++;
    endtask

    task automatic test_parity();
        int pb;
        logic v;
        logic [9:0] e;
        pb = perr_cnt;
        send_frame(8'h1B, 1'b1, 1'b1);
        n_total++;
        if ((perr_cnt - pb) != 1) $display("FAIL parity_pulse: got %0d required 1", perr_cnt - pb);
        else n_pass++;
        n_total++;
        if (key_state !== 4'b0100 || evt_valid !== 1'b0)
            $display("FAIL parity_no_effect: got keys=%b valid=%b required 0100 0", key_state, evt_valid);
        else n_pass++;
        send_frame(8'h1B, 1'b0, 1'b1);
        n_total++;
        if (key_state !== 4'b1100) $display("FAIL parity_recover_keys: got %b required 1100", key_state);
        else n_pass++;
        pop_evt(v, e);
        n_total++;
        if (v !== 1'b1 || e !== 10'h01B) $display("FAIL parity_recover_event: got v=%b %h required v=1 01b", v, e);
        else n_pass++;
        // An errored frame between prefix and code must leave the E0 flag set.
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h75, 1'b1, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        pop_evt(v, e);
        n_total++;
        if (v !== 1'b1 || e !== 10'h275) $display("FAIL parity_flag_kept: got v=%b %h required v=1 275", v, e);
        else n_pass++;
        n_total++;
        if (key_state !== 4'b1101) $display("FAIL parity_flag_keys: got %b required 1101", key_state);
        else n_pass++;
    endtask

    task automatic test_frame_err();
        int fb;
        fb = ferr_cnt;
        send_bit(1'b1);
        cyc(HALF);
        n_total++;
        if ((ferr_cnt - fb) != 1) $display("FAIL bad_start_pulse: got %0d required 1", ferr_cnt - fb);
        else n_pass++;
        send_frame(8'h1C, 1'b0, 1'b0);
        n_total++;
        if ((ferr_cnt - fb) != 2 || evt_valid !== 1'b0 || key_state !== 4'b1101)
            $display("FAIL bad_stop: got pulses=%0d valid=%b keys=%b required 2 0 1101",
                     ferr_cnt - fb, evt_valid, key_state);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int fb, waited;
        logic v;
        logic [9:0] e;
        fb = ferr_cnt;
        waited = -1;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        for (int k = 1; k <= 1000; k++) begin
            cyc(1);
            if (ferr_cnt != fb) begin
                waited = k;
                break;
            end
        end
        n_total++;
        if (waited < TMO - HALF || waited > TMO - HALF + FILT + 12)
            $display("FAIL timeout_latency: got %0d cycles required %0d..%0d",
                     waited, TMO - HALF, TMO - HALF + FILT + 12);
        else n_pass++;
        cyc(2 * TMO);
        n_total++;
        if ((ferr_cnt - fb) != 1) $display("FAIL timeout_single: got %0d pulses required 1", ferr_cnt - fb);
        else n_pass++;
        send_frame(8'h73, 1'b0, 1'b1);
        n_total++;
        if (key_state !== 4'b1111) $display("FAIL timeout_recover_keys: got %b required 1111", key_state);
        else n_pass++;
        pop_evt(v, e);
        n_total++;
        if (v !== 1'b1 || e !== 10'h073) $display("FAIL timeout_recover_event: got v=%b %h required v=1 073", v, e);
        else n_pass++;
    endtask

    task automatic test_discard();
        logic v;
        logic [9:0] e;
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b1);
        send_frame(8'h73, 1'b0, 1'b1);
        n_total++;
        if (key_state !== 4'b1111) $display("FAIL discard_keys: got %b required 1111", key_state);
        else n_pass++;
        pop_evt(v, e);
        n_total++;
        if (v !== 1'b1 || e !== 10'h073) $display("FAIL discard_event: got v=%b %h required v=1 073", v, e);
        else n_pass++;
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h72, 1'b0, 1'b1);
        n_total++;
        if (key_state !== 4'b1101) $display("FAIL arrow_break_keys: got %b required 1101", key_state);
        else n_pass++;
        pop_evt(v, e);
        n_total++;
        if (v !== 1'b1 || e !== 10'h372) $display("FAIL arrow_break_event: got v=%b %h required v=1 372", v, e);
        else n_pass++;
    endtask

    task automatic test_overflow();
        int ob;
        logic v;
        logic [9:0] e;
        logic [7:0] codes [5];
        codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h2B};
        ob = ovf_cnt;
        for (int i = 0; i < 5; i++) send_frame(codes[i], 1'b0, 1'b1);
        n_total++;
        if ((ovf_cnt - ob) != 1) $display("FAIL overflow_pulse: got %0d required 1", ovf_cnt - ob);
        else n_pass++;
        n_total++;
        if (evt_valid !== 1'b1 || evt_code !== 8'h1C || key_state !== 4'b1101)
            $display("FAIL overflow_head_stable: got v=%b code=%h keys=%b required 1 1c 1101",
                     evt_valid, evt_code, key_state);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            pop_evt(v, e);
            n_total++;
            if (v !== 1'b1 || e !== {2'b00, codes[i]})
                $display("FAIL overflow_drain_%0d: got v=%b %h required v=1 %h", i, v, e, {2'b00, codes[i]});
            else n_pass++;
        end
        n_total++;
        if (evt_valid !== 1'b0) $display("FAIL overflow_empty: got %b required 0", evt_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic v;
        logic [9:0] e;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst_n = 1'b0;
        cyc(3);
        n_total++;
        if ({evt_valid, evt_code, evt_ext, evt_break, key_state, err_parity, err_frame, overflow} !== 17'h0)
            $display("FAIL midreset_outputs: got %h required 0",
                     {evt_valid, evt_code, evt_ext, evt_break, key_state, err_parity, err_frame, overflow});
        else n_pass++;
        rst_n = 1'b1;
        cyc(5);
        send_frame(8'h75, 1'b0, 1'b1);
        n_total++;
        if (key_state !== 4'b0001) $display("FAIL midreset_keys: got %b required 0001", key_state);
        else n_pass++;
        pop_evt(v, e);
        n_total++;
        if (v !== 1'b1 || e !== 10'h075) $display("FAIL midreset_event: got v=%b %h required v=1 075", v, e);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_extended();
        test_parity();
        test_frame_err();
        test_timeout();
        test_discard();
        test_overflow();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
